// File: rtl/mux_pkg.sv
// Shared definitions for scan_mux: mode encodings, FSM states and a clog2 helper.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OUT  = 1'b1
    } state_t;

    // Returns the number of bits needed to index n items (minimum 1 for n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Round-robin channel counter for scan_mux: counts 0..N-1 and wraps, clearable.
module scan_counter
    import mux_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  CLK,
    input  logic                  notRST,
    input  logic                  clr,
    input  logic                  inc,
    output logic [clog2(N)-1:0]   cnt
);

    localparam int CW = clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Wrapping at N-1 keeps the counter inside the legal channel range for any N.
    always_ff @(posedge CLK or negedge notRST) begin
        if (!notRST) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/scan_mux.sv
// N-channel select/scan multiplexer with a registered valid/ready output port.
// Optional macro MUX_INVERT_EN: Y carries the inverted channel data and resets to all-ones.
module scan_mux
    import mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 1,
    parameter int SELW = clog2(N)
) (
    input  logic             CLK,
    input  logic             notRST,
    input  logic [N*W-1:0]   D,
    input  logic [SELW-1:0]  SEL,
    input  logic             MODE,
    input  logic             EN,
    input  logic             Y_READY,
    output logic             Y_VALID,
    output logic [W-1:0]     Y,
    output logic [SELW-1:0]  CH,
    output logic             Y_LAST,
    output logic             ERR
);

`ifdef MUX_INVERT_EN
    localparam logic [W-1:0] Y_RST = '1;
`else
    localparam logic [W-1:0] Y_RST = '0;
`endif

    state_t          state;
    logic [SELW-1:0] cnt;
    logic [SELW-1:0] ch_sel;
    logic [W-1:0]    data_sel;
    logic [W-1:0]    y_next;
    logic            in_range;
    logic            capture;
    logic            scan_clr;
    logic            scan_inc;

    assign capture  = EN & ((state == ST_IDLE) | Y_READY);
    assign ch_sel   = (MODE == MODE_SCAN) ? cnt : SEL;
    assign in_range = (32'(ch_sel) < N);
    assign scan_clr = (MODE == MODE_MANUAL);
    assign scan_inc = capture & (MODE == MODE_SCAN);

    scan_counter #(.N(N)) u_scan_counter (
        .CLK    (CLK),
        .notRST (notRST),
        .clr    (scan_clr),
        .inc    (scan_inc),
        .cnt    (cnt)
    );

    // Unmatched (out-of-range) selects fall through to zero data.
    always_comb begin
        data_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (ch_sel == SELW'(k)) begin
                data_sel = D[k*W +: W];
            end
        end
    end

`ifdef MUX_INVERT_EN
    assign y_next = ~data_sel;
`else
    assign y_next = data_sel;
`endif

    // The output register only loads on capture, so a stalled sample holds unchanged.
    always_ff @(posedge CLK or negedge notRST) begin
        if (!notRST) begin
            state   <= ST_IDLE;
            Y_VALID <= 1'b0;
            Y       <= Y_RST;
            CH      <= '0;
            Y_LAST  <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (EN) begin
                        state   <= ST_OUT;
                        Y_VALID <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (Y_READY && !EN) begin
                        state   <= ST_IDLE;
                        Y_VALID <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    Y_VALID <= 1'b0;
                end
            endcase
            if (capture) begin
                Y      <= y_next;
                CH     <= ch_sel;
                Y_LAST <= (MODE == MODE_SCAN) && (ch_sel == SELW'(N - 1));
                if ((MODE == MODE_MANUAL) && !in_range) begin
                    ERR <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised successor to the team's 4:1 combinational multiplexer.
- Selects one of N channels of W-bit data and registers it onto a valid/ready output port.
- Two modes: manual select, or automatic round-robin scan across all channels.
- Sits between parallel sample sources and a single serial consumer; the output carries the channel tag of each sample.

Parameters:
- N, 4, number of input channels (2..16).
- W, 1, data width per channel (1..32).
- SELW, $clog2(N), select/channel-tag width (derived; do not override).

Ports:
- CLK  input  1  system clock, rising edge.
- notRST  input  1  asynchronous active-low reset.
- D  input  N*W  flattened channel data; channel k occupies D[k*W +: W].
- SEL  input  SELW  channel select, used in manual mode.
- MODE  input  1  0 = manual (SEL), 1 = auto-scan.
- EN  input  1  request to capture a new sample.
- Y_READY  input  1  consumer accepts Y this cycle.
- Y_VALID  output  1  Y/CH hold a valid sample.
- Y  output  W  captured sample.
- CH  output  SELW  channel index of Y.
- Y_LAST  output  1  Y is channel N-1 in scan mode (end of sweep).
- ERR  output  1  sticky: manual SEL >= N was captured.

Behaviour:
- One clock, CLK. notRST is asynchronous, active-low.
- Reset values:
  - Y_VALID=0, CH=0, Y_LAST=0, ERR=0, scan counter=0, state=IDLE.
  - Y=0, or all-ones with MUX_INVERT_EN.
- State machine:
  - IDLE: Y_VALID=0. If EN=1, capture and go to OUT.
  - OUT: Y_VALID=1.
    - Y_READY=1 and EN=1: capture a new sample, stay in OUT; Y_VALID stays 1 with no bubble.
    - Y_READY=1 and EN=0: go to IDLE.
    - Y_READY=0: hold Y, CH, Y_LAST unchanged and ignore EN (no capture, counter frozen).
- Capture condition: EN & (state==IDLE | Y_READY).
- Latency: data sampled at the capturing edge appears on Y the same edge; one cycle from EN to Y_VALID.
- Channel choice at capture:
  - Manual: ch = SEL.
  - Scan: ch = scan counter.
- Scan counter:
  - Increments by 1 on every capture in scan mode.
  - Wraps from N-1 to 0. With N not a power of 2 it never reaches values >= N.
  - While MODE=0, the counter is held at 0, so entering scan always starts at channel 0.
- Y_LAST = MODE & (ch == N-1), registered with Y.
- Out-of-range select: manual SEL >= N (N not a power of 2) captures Y=0 (inverted: all-ones), CH=SEL, and sets ERR. ERR clears only on reset.
- MODE changing while stalled (OUT, Y_READY=0): no effect until the next capture.
- notRST asserted mid-transfer: outputs go to reset values immediately; the in-flight sample is discarded.

Optional Feature:
- Macro: MUX_INVERT_EN.
- Defined: Y captures the bitwise inverse of the selected data, matching the active-low output convention of the 4:1 mux. Y resets to all-ones.
- Undefined: true polarity; Y resets to 0.
- CH, Y_VALID, Y_LAST and ERR are unaffected in both cases.

Decomposition:
- Shared package mux_pkg holds:
  - MODE_MANUAL=1'b0 and MODE_SCAN=1'b1.
  - State encodings ST_IDLE and ST_OUT.
  - A clog2 function for SELW.
- Natural sub-module: scan_counter (parameter N). Ports: CLK, notRST, clr, inc, cnt. Implements the wrap-at-N-1 counter.
- The top level keeps the FSM, the select mux and the output registers.

Test Plan:
- Manual select: N=4, W=8, D={8'h44,8'h33,8'h22,8'h11}, MODE=0, SEL=2, EN=1, Y_READY=1. Expect Y=8'h33, CH=2, Y_VALID=1 one cycle after EN.
- Scan wrap: MODE=1, EN=1 continuously, Y_READY=1. Expect CH sequence 0,1,2,3,0; Y_LAST=1 only with CH=3; Y_VALID high with no gaps.
- Backpressure: scan mode, Y_READY=0 for 3 cycles after CH=1. Expect Y/CH frozen at channel 1; next accepted sample is CH=2 (no channel skipped).
- Out of range: N=3, MODE=0, SEL=3, EN=1. Expect Y=0, CH=3, ERR=1; ERR stays 1 after SEL returns to 0.
- Reset mid-scan: assert notRST low between clock edges while CH=2. Expect Y_VALID=0 and CH=0 immediately; after release, the first scan capture is CH=0.
- Inversion: with MUX_INVERT_EN, D channel 0=8'hA5, SEL=0. Expect Y=8'h5A; Y=8'hFF during reset.
